// File: rtl/muxn_pipe.sv
// rtl/muxn_pipe.sv - pipelined N:1 word mux built from registered 4:1 levels (final 2:1 when SELW is odd)
// Optional out_par output (registered even parity of the selected word) under MUXN_PIPE_PARITY_EN.
module muxn_pipe #(
  parameter int WIDTH  = 64,
  parameter int N      = 16,
  parameter int SELW   = $clog2(N),
  parameter int LEVELS = (SELW + 1) / 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   w,
  input  logic [SELW-1:0]      sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef MUXN_PIPE_PARITY_EN
  ,
  output logic                 out_par
`endif
);

  // w_rdy[k] is the ready of level k; w_rdy[LEVELS] is the consumer's ready.
  logic [LEVELS:0] w_rdy;

  assign w_rdy[LEVELS] = out_ready;
  assign in_ready      = w_rdy[0];

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int SIN   = SELW - 2*k;
    localparam int SB    = (SIN == 1) ? 1 : 2;
    localparam int GRP   = 1 << SB;
    localparam int IN_W  = 1 << SIN;
    localparam int OUT_W = IN_W / GRP;

    logic [IN_W*WIDTH-1:0]  w_din;
    logic [SIN-1:0]         w_sin;
    logic                   w_vin;
    logic                   w_load;
    logic [OUT_W*WIDTH-1:0] w_mux;
    logic [OUT_W*WIDTH-1:0] r_data;
    logic                   r_v;

    if (k == 0) begin : g_src
      assign w_din  = w;
      assign w_sin  = sel;
      assign w_vin  = in_valid;
      assign w_load = w_rdy[k] & in_valid;
    end else begin : g_src
      assign w_din  = g_lvl[k-1].r_data;
      assign w_sin  = g_lvl[k-1].g_sel.r_sel;
      assign w_vin  = g_lvl[k-1].r_v;
      assign w_load = w_rdy[k];
    end

    assign w_rdy[k] = ~r_v | w_rdy[k+1];

    always_comb begin
      w_mux = '0;
      for (int j = 0; j < OUT_W; j++) begin
        w_mux[j*WIDTH +: WIDTH] = w_din[(j*GRP + int'(w_sin[SB-1:0]))*WIDTH +: WIDTH];
      end
    end

    // A stalled level keeps data, sel and valid so a held output stays stable.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_v    <= 1'b0;
        r_data <= '0;
      end else if (w_rdy[k]) begin
        r_v <= w_vin;
        if (w_load) begin
          r_data <= w_mux;
        end
      end
    end

    if (SIN > SB) begin : g_sel
      logic [SIN-SB-1:0] r_sel;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_sel <= '0;
        end else if (w_load) begin
          r_sel <= w_sin[SIN-1:SB];
        end
      end
    end

`ifdef MUXN_PIPE_PARITY_EN
    logic [OUT_W-1:0] w_pmux;
    logic [OUT_W-1:0] r_par;

    if (k == 0) begin : g_par
      always_comb begin
        w_pmux = '0;
        for (int j = 0; j < OUT_W; j++) begin
          w_pmux[j] = ^w_mux[j*WIDTH +: WIDTH];
        end
      end
    end else begin : g_par
      logic [IN_W-1:0] w_pin;

      assign w_pin = g_lvl[k-1].r_par;

      always_comb begin
        w_pmux = '0;
        for (int j = 0; j < OUT_W; j++) begin
          w_pmux[j] = w_pin[j*GRP + int'(w_sin[SB-1:0])];
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_par <= '0;
      end else if (w_load) begin
        r_par <= w_pmux;
      end
    end
`endif
  end

  assign out       = g_lvl[LEVELS-1].r_data;
  assign out_valid = g_lvl[LEVELS-1].r_v;

`ifdef MUXN_PIPE_PARITY_EN
  assign out_par = g_lvl[LEVELS-1].r_par[0];
`endif

endmodule

// File: tb/tb_muxn_pipe.sv
// tb/tb_muxn_pipe.sv - directed self-checking bench for muxn_pipe (N=16, WIDTH=8)
module tb_muxn_pipe;
  localparam int WIDTH = 8;
  localparam int N     = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N*WIDTH-1:0]   w_bus;
  logic [3:0]           sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out;
  logic                 out_valid;
  logic                 out_ready;
`ifdef MUXN_PIPE_PARITY_EN
  logic                 out_par;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  muxn_pipe #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .w         (w_bus),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUXN_PIPE_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    sel       = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) w_bus[i*WIDTH +: WIDTH] = 8'hA0 + 8'(i);

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Sweep
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      in_valid = (i < 16);
      sel      = i[3:0];
      tick();
      check("sweep_valid", out_valid, (i >= 1 && i <= 16));
      if (i >= 1 && i <= 16) check("sweep_data", out, 8'hA0 + i - 1);
    end

    // Full stall
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 4'd3;
    #1 check("stall_rdy3", in_ready, 1);
    tick();
    sel = 4'd7;
    #1 check("stall_rdy7", in_ready, 1);
    tick();
    check("stall_valid", out_valid, 1);
    check("stall_a3", out, 8'hA3);
    sel = 4'd9;
    #1 check("stall_rdy9", in_ready, 0);
    tick();
    check("stall_hold1", out, 8'hA3);
    tick();
    check("stall_hold2", out, 8'hA3);
    check("stall_hold_v", out_valid, 1);
    out_ready = 1'b1;
    #1 check("stall_rel_rdy", in_ready, 1);
    check("stall_rel_a3", out, 8'hA3);
    tick();
    in_valid = 1'b0;
    check("stall_a7", out, 8'hA7);
    tick();
    check("stall_a9", out, 8'hA9);
    check("stall_a9_v", out_valid, 1);
    tick();
    check("stall_drained", out_valid, 0);

    // Bubble collapse
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 4'd5;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("bub_a5", out, 8'hA5);
    in_valid = 1'b1;
    sel      = 4'd6;
    #1 check("bub_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bub_hold", out, 8'hA5);
    out_ready = 1'b1;
    tick();
    check("bub_a6", out, 8'hA6);
    check("bub_a6_v", out_valid, 1);
    tick();
    check("bub_drained", out_valid, 0);

    // Simultaneous in/out transfer on a full pipe
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 4'd1;
    tick();
    sel = 4'd2;
    tick();
    sel = 4'd15;
    #1 check("sim_full_rdy", in_ready, 0);
    out_ready = 1'b1;
    #1 check("sim_rdy", in_ready, 1);
    check("sim_a1", out, 8'hA1);
    tick();
    out_ready = 1'b0;
    #1 check("sim_occ_rdy", in_ready, 0);
    check("sim_a2", out, 8'hA2);
    check("sim_a2_v", out_valid, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("sim_af", out, 8'hAF);
    tick();
    check("sim_drained", out_valid, 0);

    // Mid-run reset
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 4'd4;
    tick();
    sel = 4'd8;
    tick();
    in_valid = 1'b0;
    check("mrst_pre_v", out_valid, 1);
    #1 reset = 1'b1;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_out", out, 0);
    check("mrst_rdy", in_ready, 1);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sel       = 4'd0;
    #1 check("mrst_post_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("mrst_no_ghost", out_valid, 0);
    tick();
    check("mrst_a0_v", out_valid, 1);
    check("mrst_a0", out, 8'hA0);
    tick();
    check("mrst_drained", out_valid, 0);

`ifdef MUXN_PIPE_PARITY_EN
    out_ready = 1'b1;
    w_bus[2*WIDTH +: WIDTH] = 8'h07;
    in_valid = 1'b1;
    sel      = 4'd2;
    tick();
    in_valid = 1'b0;
    tick();
    check("par_out07", out, 8'h07);
    check("par_07", out_par, 1);
    w_bus[2*WIDTH +: WIDTH] = 8'h03;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("par_out03", out, 8'h03);
    check("par_03", out_par, 0);
    w_bus[2*WIDTH +: WIDTH] = 8'hA2;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
